fmac_ws_array_ctrl: RTL and testbench

//  Sequencer for a ROWS x COLS weight-stationary array of fmac_ws PEs.

---
 rtl/fmac_ws_pkg.sv | 16 +
 rtl/fmac_ws_array_ctrl_if.sv | 36 +++
 rtl/fmac_ws_delay_line.sv | 36 +++
 rtl/fmac_ws_array_ctrl.sv | 124 ++++++++++++
 tb/tb_fmac_ws_array_ctrl.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fmac_ws_pkg.sv
// rtl/fmac_ws_pkg.sv - shared phase encoding and BFP widths for the weight-stationary array
package fmac_ws_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } ws_phase_e;

    localparam int BFPEXPSIZE = 8;
    localparam int BFPMANSIZE = 4;
    localparam int GRPSIZE    = 16;

endpackage

// File: rtl/fmac_ws_array_ctrl_if.sv
// rtl/fmac_ws_array_ctrl_if.sv - job, weight, activation and result handshakes of the array sequencer
interface fmac_ws_array_ctrl_if #(
    parameter int ROWS = 4,
    parameter int MAXK = 256
);
    localparam int KW = $clog2(MAXK + 1);

    logic            i_start;
    logic [KW-1:0]   i_num_groups;
    logic            o_busy;
    logic            o_done;
    logic            i_w_valid;
    logic            o_w_ready;
    logic [ROWS-1:0] o_pre_store;
    logic            i_act_valid;
    logic            o_act_ready;
    logic [ROWS-1:0] o_row_en;
    logic            o_array_en;
    logic            o_res_valid;
    logic            o_res_last;
    logic            i_res_ready;
    logic [2:0]      o_phase;

    modport master (
        output i_start, i_num_groups, i_w_valid, i_act_valid, i_res_ready,
        input  o_busy, o_done, o_w_ready, o_pre_store, o_act_ready, o_row_en,
               o_array_en, o_res_valid, o_res_last, o_phase
    );

    modport slave (
        input  i_start, i_num_groups, i_w_valid, i_act_valid, i_res_ready,
        output o_busy, o_done, o_w_ready, o_pre_store, o_act_ready, o_row_en,
               o_array_en, o_res_valid, o_res_last, o_phase
    );

endinterface

// File: rtl/fmac_ws_delay_line.sv
// rtl/fmac_ws_delay_line.sv - enable-gated shift register with synchronous clear
module fmac_ws_delay_line #(
    parameter int DEPTH  = 1,
    parameter int W      = 1,
    parameter bit TAPPED = 1'b0
) (
    input  logic                                 clk,
    input  logic                                 clear,
    input  logic                                 en,
    input  logic [W-1:0]                         d,
    output logic [(TAPPED ? DEPTH*W : W)-1:0]    q
);

    logic [W-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else if (en) begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    // Tapped form exposes every stage (stage i = input delayed i+1); otherwise only the tail.
    generate
        if (TAPPED) begin : g_taps
            for (genvar i = 0; i < DEPTH; i++) begin : g_tap
                assign q[i*W +: W] = stage[i];
            end
        end else begin : g_last
            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/fmac_ws_array_ctrl.sv
// rtl/fmac_ws_array_ctrl.sv - job sequencer for a ROWS x COLS weight-stationary fmac_ws array
module fmac_ws_array_ctrl
    import fmac_ws_pkg::*;
#(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int MAXK   = 256,
    parameter int PE_LAT = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    fmac_ws_array_ctrl_if.slave  bus
);

    localparam int KW  = $clog2(MAXK + 1);
    localparam int WIW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int L   = ROWS + COLS - 1 + PE_LAT;

    ws_phase_e       state, state_n;
    logic [KW-1:0]   k_q, ai_q;
    logic [WIW-1:0]  wi_q;

    logic            w_fire, act_fire, last_act;
    logic            w_ready, act_ready, busy, done;
    logic [ROWS-1:0] pre_store;
    logic            array_en, res_valid, res_last;
    logic [1:0]      res_tail;
    logic [ROWS-2:0] skew_taps;

    assign res_valid = res_tail[1];
    assign res_last  = res_tail[0];
    // A result waiting on a stalled sink freezes the whole array, including injection.
    assign array_en  = ~(res_valid & ~bus.i_res_ready);
    assign last_act  = (ai_q == k_q - 1'b1);

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= IDLE;
        else         state <= state_n;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            k_q  <= '0;
            ai_q <= '0;
            wi_q <= '0;
        end else begin
            if (state == IDLE && bus.i_start) begin
                k_q  <= bus.i_num_groups;
                ai_q <= '0;
                wi_q <= '0;
            end
            if (w_fire)   wi_q <= wi_q + 1'b1;
            if (act_fire) ai_q <= ai_q + 1'b1;
        end
    end

    always_comb begin
        state_n   = state;
        w_ready   = 1'b0;
        w_fire    = 1'b0;
        pre_store = '0;
        act_ready = 1'b0;
        act_fire  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_start) state_n = LOAD_W;
            end
            LOAD_W: begin
                busy    = 1'b1;
                w_ready = 1'b1;
                if (bus.i_w_valid) begin
                    w_fire    = 1'b1;
                    pre_store = ROWS'(1) << wi_q;
                    if (wi_q == WIW'(ROWS - 1)) state_n = (k_q != '0) ? STREAM : DONE;
                end
            end
            STREAM: begin
                busy      = 1'b1;
                act_ready = array_en & (ai_q < k_q);
                act_fire  = act_ready & bus.i_act_valid;
                if (act_fire && last_act) state_n = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (res_valid && res_last && bus.i_res_ready) state_n = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    fmac_ws_delay_line #(.DEPTH(L), .W(2), .TAPPED(1'b0)) u_res_line (
        .clk   (i_clk),
        .clear (i_reset),
        .en    (array_en),
        .d     ({act_fire, act_fire & last_act}),
        .q     (res_tail)
    );

    fmac_ws_delay_line #(.DEPTH(ROWS - 1), .W(1), .TAPPED(1'b1)) u_skew_line (
        .clk   (i_clk),
        .clear (i_reset),
        .en    (array_en),
        .d     (act_fire),
        .q     (skew_taps)
    );

    assign bus.o_busy      = busy;
    assign bus.o_done      = done;
    assign bus.o_w_ready   = w_ready;
    assign bus.o_pre_store = pre_store;
    assign bus.o_act_ready = act_ready;
    assign bus.o_row_en    = {skew_taps, act_fire};
    assign bus.o_array_en  = array_en;
    assign bus.o_res_valid = res_valid;
    assign bus.o_res_last  = res_last;
    assign bus.o_phase     = state;

endmodule

// File: tb/tb_fmac_ws_array_ctrl.sv
// tb/tb_fmac_ws_array_ctrl.sv - self-checking bench for fmac_ws_array_ctrl
module tb_fmac_ws_array_ctrl;
    import fmac_ws_pkg::*;

    localparam int ROWS = 4, COLS = 4, MAXK = 256, PE_LAT = 2;
    localparam int L  = ROWS + COLS - 1 + PE_LAT;
    localparam int KW = $clog2(MAXK + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fmac_ws_array_ctrl_if #(.ROWS(ROWS), .MAXK(MAXK)) bus();

    fmac_ws_array_ctrl #(.ROWS(ROWS), .COLS(COLS), .MAXK(MAXK), .PE_LAT(PE_LAT)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: job progress counts plus a queue of results keyed by enabled-cycle tick.
    typedef struct { int due; bit last; } res_t;
    bit   m_live = 0, m_busy = 0, m_done_ph = 0, m_last_taken = 0;
    int   m_k = 0, m_nw = 0, m_na = 0, m_tick = 0;
    res_t m_res[$];
    int   m_acc[$];

    function automatic ws_phase_e m_phase();
        if (m_done_ph) return DONE;
        if (!m_busy) return IDLE;
        if (m_nw < ROWS) return LOAD_W;
        if (m_na < m_k) return STREAM;
        return DRAIN;
    endfunction

    function automatic bit m_res_valid();
        return (m_res.size() > 0) && (m_res[0].due == m_tick);
    endfunction

    function automatic bit m_res_last();
        return m_res_valid() && m_res[0].last;
    endfunction

    function automatic bit m_array_en();
        return !(m_res_valid() && !bus.i_res_ready);
    endfunction

    function automatic bit m_act_ready();
        return (m_phase() == STREAM) && m_array_en();
    endfunction

    function automatic logic [ROWS-1:0] m_pre_store();
        logic [ROWS-1:0] v = '0;
        if (m_phase() == LOAD_W && bus.i_w_valid) v[m_nw] = 1'b1;
        return v;
    endfunction

    function automatic logic [ROWS-1:0] m_row_en();
        logic [ROWS-1:0] v = '0;
        v[0] = m_act_ready() && bus.i_act_valid;
        for (int r = 1; r < ROWS; r++)
            foreach (m_acc[j]) if (m_acc[j] == m_tick - r) v[r] = 1'b1;
        return v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_live = 1; m_busy = 0; m_done_ph = 0; m_last_taken = 0;
            m_k = 0; m_nw = 0; m_na = 0; m_tick = 0;
            m_res.delete(); m_acc.delete();
        end else if (m_live) begin
            ws_phase_e ph;
            bit en, rv, rl, ar;
            ph = m_phase(); en = m_array_en(); rv = m_res_valid(); rl = m_res_last(); ar = m_act_ready();
            if (ph == DONE) begin
                m_done_ph = 0; m_busy = 0;
            end else if (ph == IDLE) begin
                if (bus.i_start) begin
                    m_busy = 1; m_k = int'(bus.i_num_groups); m_nw = 0; m_na = 0; m_last_taken = 0;
                end
            end else begin
                if (ph == LOAD_W && bus.i_w_valid) m_nw++;
                if (ar && bus.i_act_valid) begin
                    m_res.push_back('{due: m_tick + L, last: (m_na == m_k - 1)});
                    m_acc.push_back(m_tick);
                    if (m_acc.size() > ROWS) void'(m_acc.pop_front());
                    m_na++;
                end
                if (rv && bus.i_res_ready) begin
                    if (rl) m_last_taken = 1;
                    void'(m_res.pop_front());
                end
                if (m_nw == ROWS && m_na == m_k && (m_k == 0 || m_last_taken)) m_done_ph = 1;
            end
            if (en) m_tick++;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("phase",     bus.o_phase,     m_phase());
            chk("busy",      bus.o_busy,      (m_phase() inside {LOAD_W, STREAM, DRAIN}));
            chk("done",      bus.o_done,      (m_phase() == DONE));
            chk("w_ready",   bus.o_w_ready,   (m_phase() == LOAD_W));
            chk("pre_store", bus.o_pre_store, m_pre_store());
            chk("act_ready", bus.o_act_ready, m_act_ready());
            chk("row_en",    bus.o_row_en,    m_row_en());
            chk("array_en",  bus.o_array_en,  m_array_en());
            chk("res_valid", bus.o_res_valid, m_res_valid());
            chk("res_last",  bus.o_res_last,  m_res_last());
        end
    end

    // Per-job logs of observed events, indexed by cycles since the start pulse.
    int              acc_cyc[$], res_cyc[$], pre_cyc[$];
    bit              res_lst[$];
    logic [ROWS-1:0] pre_val[$];
    logic [ROWS-1:0] rowen_log [600];
    int              arr_low;
    bit              any_act_ready;

    task automatic run_job(input int k, input bit gappy, input int stall_len,
                           input int abort_acc, input bit spur, output int done_cyc);
        bit seen;
        int stall_left;
        acc_cyc.delete(); res_cyc.delete(); pre_cyc.delete(); res_lst.delete(); pre_val.delete();
        arr_low = 0; any_act_ready = 0; done_cyc = -1; seen = 0; stall_left = 0;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            bus.i_start = (c == 0) ||
                          (spur && (bus.o_phase == 3'(STREAM) || bus.o_phase == 3'(DONE)));
            bus.i_num_groups = KW'(k);
            bus.i_w_valid   = gappy ? (c % 2 == 1) : 1'b1;
            bus.i_act_valid = gappy ? (c % 2 == 0) : 1'b1;
            if (stall_len > 0 && !seen && bus.o_res_valid) begin
                seen = 1; stall_left = stall_len;
            end
            bus.i_res_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            @(negedge clk);
            rowen_log[c] = bus.o_row_en;
            if (bus.o_pre_store != '0) begin pre_cyc.push_back(c); pre_val.push_back(bus.o_pre_store); end
            if (bus.o_act_ready) any_act_ready = 1;
            if (bus.i_act_valid && bus.o_act_ready) acc_cyc.push_back(c);
            if (bus.o_res_valid && bus.i_res_ready) begin res_cyc.push_back(c); res_lst.push_back(bus.o_res_last); end
            if (!bus.o_array_en) arr_low++;
            if (abort_acc > 0 && acc_cyc.size() == abort_acc) break;
            if (bus.o_done) begin done_cyc = c; break; end
        end
        bus.i_start = 0; bus.i_w_valid = 0; bus.i_act_valid = 0; bus.i_res_ready = 1;
        if (abort_acc == 0) chk("job_completes", (done_cyc >= 0), 1);
    endtask

    int d, d_nostall;

    initial begin
        bus.i_start = 0; bus.i_num_groups = '0; bus.i_w_valid = 0;
        bus.i_act_valid = 0; bus.i_res_ready = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_done", bus.o_done, 0);
        chk("rst_w_ready", bus.o_w_ready, 0);
        chk("rst_pre_store", bus.o_pre_store, 0);
        chk("rst_act_ready", bus.o_act_ready, 0);
        chk("rst_row_en", bus.o_row_en, 0);
        chk("rst_res_valid", bus.o_res_valid, 0);
        chk("rst_res_last", bus.o_res_last, 0);
        chk("rst_array_en", bus.o_array_en, 1);
        chk("rst_phase", bus.o_phase, 0);

        // Reset in the middle of streaming drops everything.
        run_job(8, 0, 0, 3, 0, d);
        chk("abort_acc_count", acc_cyc.size(), 3);
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        chk("midrst_phase", bus.o_phase, 0);
        chk("midrst_res_valid", bus.o_res_valid, 0);
        chk("midrst_busy", bus.o_busy, 0);
        begin
            int seen_done = 0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (bus.o_done || bus.o_res_valid) seen_done++;
            end
            chk("midrst_no_done_or_result", seen_done, 0);
        end

        // Basic K=3 job.
        run_job(3, 0, 0, 0, 0, d);
        chk("k3_done_cycle", d, 17);
        chk("k3_pre_count", pre_cyc.size(), 4);
        for (int i = 0; i < 4 && i < pre_cyc.size(); i++) begin
            chk("k3_pre_cycle", pre_cyc[i], i + 1);
            chk("k3_pre_value", pre_val[i], 1 << i);
        end
        chk("k3_acc_count", acc_cyc.size(), 3);
        chk("k3_res_count", res_cyc.size(), 3);
        for (int i = 0; i < 3 && i < acc_cyc.size() && i < res_cyc.size(); i++) begin
            chk("k3_acc_cycle", acc_cyc[i], 5 + i);
            chk("k3_res_latency", res_cyc[i] - acc_cyc[i], 9);
            chk("k3_res_last", res_lst[i], (i == 2));
            for (int r = 0; r < ROWS; r++) chk("k3_row_skew", rowen_log[acc_cyc[i] + r][r], 1);
        end
        if (res_cyc.size() == 3) chk("k3_done_after_last", d, res_cyc[2] + 1);

        // K=0: weights only.
        run_job(0, 0, 0, 0, 0, d);
        chk("k0_done_cycle", d, 5);
        chk("k0_pre_count", pre_cyc.size(), 4);
        chk("k0_act_ready_never", any_act_ready, 0);

        // Backpressure on the first result.
        run_job(4, 0, 0, 0, 0, d_nostall);
        chk("k4_nostall_done", d_nostall, 18);
        run_job(4, 0, 5, 0, 0, d);
        chk("k4_stall_done", d, 23);
        chk("k4_stall_growth", d - d_nostall, 5);
        chk("k4_stall_cycles", arr_low, 5);
        chk("k4_res_count", res_cyc.size(), 4);
        for (int i = 0; i < res_cyc.size(); i++) chk("k4_res_last", res_lst[i], (i == 3));

        // Stall while activations are still being injected.
        run_job(12, 0, 3, 0, 0, d);
        chk("k12_stall_res_count", res_cyc.size(), 12);
        chk("k12_stall_cycles", arr_low, 3);

        // Gappy weight and activation sources.
        run_job(3, 1, 0, 0, 0, d);
        chk("gap_done_cycle", d, 22);
        chk("gap_pre_count", pre_cyc.size(), 4);
        for (int i = 0; i < pre_cyc.size(); i++) begin
            chk("gap_pre_cycle", pre_cyc[i], 2 * i + 1);
            chk("gap_pre_value", pre_val[i], 1 << i);
        end
        chk("gap_res_count", res_cyc.size(), 3);
        for (int i = 1; i < 3 && i < res_cyc.size() && i < acc_cyc.size(); i++)
            chk("gap_res_spacing", res_cyc[i] - res_cyc[i-1], acc_cyc[i] - acc_cyc[i-1]);

        // Spurious starts during STREAM and DONE, then a clean second job.
        run_job(2, 0, 0, 0, 1, d);
        chk("spur_done_cycle", d, 16);
        run_job(2, 0, 0, 0, 0, d);
        chk("second_job_done_cycle", d, 16);
        chk("second_job_pre_first", (pre_val.size() > 0) ? pre_val[0] : 0, 1);
        chk("second_job_acc_first", (acc_cyc.size() > 0) ? acc_cyc[0] : 0, 5);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got time %0t expected completion", $time);
        $fatal(1, "timeout");
    end

endmodule
